sram_arbiter: RTL and testbench

// - Owns the single external SRAM bus (21-bit address, 8-bit data) and shares it between three requesters:

---
 rtl/sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM bus (21-bit address, 8-bit data)
// between the loader, video fetch and CPU requesters (plus an optional DMA
// requester). Each transfer is IDLE/DONE-arbitrated, then runs ACC_CYCLES
// strobe cycles followed by a single DONE cycle that acks the owner.
// Optional feature macro: SRAM_ARB_DMA_EN (adds the dma_* ports, owner 4).
`timescale 1ns/1ps

module sram_arbiter #(
  parameter int ACC_CYCLES     = 2,
  parameter int CPU_STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  // loader
  input  logic        ldr_req,
  input  logic        ldr_wr,
  input  logic [20:0] ldr_a,
  input  logic [7:0]  ldr_d,
  output logic        ldr_ack,
  // video fetch (read only)
  input  logic        vid_req,
  input  logic [20:0] vid_a,
  output logic [7:0]  vid_q,
  output logic        vid_ack,
  // CPU
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [20:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_ack,
`ifdef SRAM_ARB_DMA_EN
  // DMA
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [20:0] dma_a,
  input  logic [7:0]  dma_d,
  output logic [7:0]  dma_q,
  output logic        dma_ack,
`endif
  // SRAM pads
  output logic [20:0] sram_a,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [2:0]  owner
);

  localparam int SW = (CPU_STARVE_MAX < 1) ? 1 : $clog2(CPU_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_MAX);
  localparam logic [2:0]    ACC_LAST   = 3'(ACC_CYCLES - 1);

  localparam logic [2:0] OWN_NONE = 3'd0;
  localparam logic [2:0] OWN_CPU  = 3'd1;
  localparam logic [2:0] OWN_VID  = 3'd2;
  localparam logic [2:0] OWN_LDR  = 3'd3;
  localparam logic [2:0] OWN_DMA  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // DMA requester view; constant-idle when the feature is not built
  logic        dma_req_s;
  logic        dma_wr_s;
  logic [20:0] dma_a_s;
  logic [7:0]  dma_d_s;
`ifdef SRAM_ARB_DMA_EN
  assign dma_req_s = dma_req;
  assign dma_wr_s  = dma_wr;
  assign dma_a_s   = dma_a;
  assign dma_d_s   = dma_d;
`else
  assign dma_req_s = 1'b0;
  assign dma_wr_s  = 1'b0;
  assign dma_a_s   = '0;
  assign dma_d_s   = '0;
`endif

  // state and datapath registers
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [20:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    vid_rd_q, vid_rd_d;
  logic [7:0]    cpu_rd_q, cpu_rd_d;
  // registered pad strobes and acks
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic          doe_q, doe_d;
  logic          ldr_ack_q, ldr_ack_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
`ifdef SRAM_ARB_DMA_EN
  logic [7:0]    dma_rd_q, dma_rd_d;
  logic          dma_ack_q, dma_ack_d;
`endif

  // arbitration signals
  logic       ldr_m, vid_m, cpu_m, dma_m;
  logic       force_cpu;
  logic       grant;
  logic [2:0] win;

  // Fixed priority ldr > vid > dma > cpu; a starved CPU jumps ahead of
  // everything except the loader.
  function automatic logic [2:0] pick_owner(input logic l, input logic v,
                                            input logic d, input logic c,
                                            input logic f);
    logic [2:0] r;
    r = OWN_NONE;
    if (l)           r = OWN_LDR;
    else if (c && f) r = OWN_CPU;
    else if (v)      r = OWN_VID;
    else if (d)      r = OWN_DMA;
    else if (c)      r = OWN_CPU;
    return r;
  endfunction

  // Arbitration: the finishing owner still holds its request during DONE,
  // so it is masked out there; otherwise it would be re-granted spuriously.
  always_comb begin
    ldr_m     = ldr_req   && !((state_q == ST_DONE) && (owner_q == OWN_LDR));
    vid_m     = vid_req   && !((state_q == ST_DONE) && (owner_q == OWN_VID));
    cpu_m     = cpu_req   && !((state_q == ST_DONE) && (owner_q == OWN_CPU));
    dma_m     = dma_req_s && !((state_q == ST_DONE) && (owner_q == OWN_DMA));
    force_cpu = (starve_q == STARVE_MAX);
    win       = pick_owner(ldr_m, vid_m, dma_m, cpu_m, force_cpu);
    grant     = (state_q != ST_ACCESS) && (win != OWN_NONE);
  end

  // Next-state, transfer latch, read capture, starvation count and the
  // registered pad/ack values derived from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    vid_rd_d = vid_rd_q;
    cpu_rd_d = cpu_rd_q;
`ifdef SRAM_ARB_DMA_EN
    dma_rd_d = dma_rd_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        if (cnt_q == ACC_LAST) begin
          state_d = ST_DONE;
          // read data is captured on the edge that closes the last strobe cycle
          if (!wr_q) begin
            case (owner_q)
              OWN_VID: vid_rd_d = sram_din;
              OWN_CPU: cpu_rd_d = sram_din;
`ifdef SRAM_ARB_DMA_EN
              OWN_DMA: dma_rd_d = sram_din;
`endif
              default: ;
            endcase
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    if (grant) begin
      state_d = ST_ACCESS;
      cnt_d   = 3'd0;
      owner_d = win;
      case (win)
        OWN_LDR: begin
          wr_d    = ldr_wr;
          addr_d  = ldr_a;
          wdata_d = ldr_d;
        end
        OWN_VID: begin
          wr_d    = 1'b0;
          addr_d  = vid_a;
        end
        OWN_DMA: begin
          wr_d    = dma_wr_s;
          addr_d  = dma_a_s;
          wdata_d = dma_d_s;
        end
        default: begin
          wr_d    = cpu_wr;
          addr_d  = cpu_a;
          wdata_d = cpu_d;
        end
      endcase
    end

    // starvation guard counts non-CPU grants while a fresh CPU request waits
    if (!cpu_m) begin
      starve_d = '0;
    end else if (grant) begin
      if (win == OWN_CPU)
        starve_d = '0;
      else if (starve_q != STARVE_MAX)
        starve_d = starve_q + SW'(1);
    end

    we_n_d    = !((state_d == ST_ACCESS) && wr_d);
    oe_n_d    = !((state_d == ST_ACCESS) && !wr_d);
    doe_d     = (state_d != ST_IDLE) && wr_d;
    ldr_ack_d = (state_d == ST_DONE) && (owner_d == OWN_LDR);
    vid_ack_d = (state_d == ST_DONE) && (owner_d == OWN_VID);
    cpu_ack_d = (state_d == ST_DONE) && (owner_d == OWN_CPU);
`ifdef SRAM_ARB_DMA_EN
    dma_ack_d = (state_d == ST_DONE) && (owner_d == OWN_DMA);
`endif
  end

  // State register with asynchronous reset (aborts an in-flight transfer)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      owner_q   <= OWN_NONE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      vid_rd_q  <= '0;
      cpu_rd_q  <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      doe_q     <= 1'b0;
      ldr_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
`ifdef SRAM_ARB_DMA_EN
      dma_rd_q  <= '0;
      dma_ack_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      vid_rd_q  <= vid_rd_d;
      cpu_rd_q  <= cpu_rd_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      doe_q     <= doe_d;
      ldr_ack_q <= ldr_ack_d;
      vid_ack_q <= vid_ack_d;
      cpu_ack_q <= cpu_ack_d;
`ifdef SRAM_ARB_DMA_EN
      dma_rd_q  <= dma_rd_d;
      dma_ack_q <= dma_ack_d;
`endif
    end
  end

  assign sram_a    = addr_q;
  assign sram_dout = wdata_q;
  assign sram_doe  = doe_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign owner     = owner_q;
  assign ldr_ack   = ldr_ack_q;
  assign vid_ack   = vid_ack_q;
  assign vid_q     = vid_rd_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_q     = cpu_rd_q;
`ifdef SRAM_ARB_DMA_EN
  assign dma_ack   = dma_ack_q;
  assign dma_q     = dma_rd_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed bench for sram_arbiter with an
// SRAM memory model, per-requester scoreboards and a transaction-level
// reference model of grant order and bus timing.
`timescale 1ns/1ps

module tb_sram_arbiter;
  localparam int AC   = 2;
  localparam int SMAX = 3;
  localparam int TO_CYCLES = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ldr_req = 0, ldr_wr = 0;
  logic [20:0] ldr_a = 0;
  logic [7:0]  ldr_d = 0;
  logic        ldr_ack;
  logic        vid_req = 0;
  logic [20:0] vid_a = 0;
  logic [7:0]  vid_q;
  logic        vid_ack;
  logic        cpu_req = 0, cpu_wr = 0;
  logic [20:0] cpu_a = 0;
  logic [7:0]  cpu_d = 0;
  logic [7:0]  cpu_q;
  logic        cpu_ack;
  logic        dma_req = 0, dma_wr = 0;
  logic [20:0] dma_a = 0;
  logic [7:0]  dma_d = 0;
  logic [7:0]  dma_q;
  logic        dma_ack;
  logic [20:0] sram_a;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din = 8'h00;
  logic        sram_we_n, sram_oe_n;
  logic [2:0]  owner;

`ifndef SRAM_ARB_DMA_EN
  assign dma_ack = 1'b0;
  assign dma_q   = 8'h00;
`endif

  sram_arbiter #(.ACC_CYCLES(AC), .CPU_STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_a(ldr_a), .ldr_d(ldr_d), .ldr_ack(ldr_ack),
    .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_ack(cpu_ack),
`ifdef SRAM_ARB_DMA_EN
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_a(dma_a), .dma_d(dma_d), .dma_q(dma_q), .dma_ack(dma_ack),
`endif
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .owner(owner)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model and reference memory ----------------
  logic [7:0] mem [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_val(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction
  function automatic logic [7:0] mem_get(input logic [20:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : init_val(a);
  endfunction
  function automatic logic [7:0] ref_get(input logic [20:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (!sram_we_n && sram_doe) mem[int'(sram_a)] = sram_dout;
    sram_din = !sram_oe_n ? mem_get(sram_a) : 8'h00;
  end

  // ---------------- scoreboards ----------------
  typedef struct {
    logic        wr;
    logic [20:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
  } item_t;
  item_t sb_cpu[$];
  item_t sb_vid[$];
  item_t sb_ldr[$];
  item_t sb_dma[$];

  function automatic logic ack_of(input int who);
    case (who)
      1: return cpu_ack;
      2: return vid_ack;
      3: return ldr_ack;
      default: return dma_ack;
    endcase
  endfunction

  // Issue one transfer for a requester, hold it until ack, then release.
  // Caller starts just after a rising edge; returns just after a rising edge.
  task automatic issue(input int who, input logic wr, input logic [20:0] a,
                       input logic [7:0] d, output int lat);
    item_t it;
    int    cyc;
    logic  got;
    it.wr = wr; it.a = a; it.d = d;
    it.q  = wr ? 8'h00 : ref_get(a);
    if (wr) ref_mem[int'(a)] = d;
    case (who)
      1: begin sb_cpu.push_back(it); cpu_wr = wr; cpu_a = a; cpu_d = d; cpu_req = 1'b1; end
      2: begin sb_vid.push_back(it); vid_a = a; vid_req = 1'b1; end
      3: begin sb_ldr.push_back(it); ldr_wr = wr; ldr_a = a; ldr_d = d; ldr_req = 1'b1; end
      default: begin sb_dma.push_back(it); dma_wr = wr; dma_a = a; dma_d = d; dma_req = 1'b1; end
    endcase
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TO_CYCLES) begin
      @(negedge clk);
      cyc++;
      got = ack_of(who);
    end
    lat = cyc;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: requester %0d got no ack within %0d cycles", who, TO_CYCLES);
    end
    @(posedge clk); #1;
    case (who)
      1: cpu_req = 1'b0;
      2: vid_req = 1'b0;
      3: ldr_req = 1'b0;
      default: dma_req = 1'b0;
    endcase
  endtask

  function automatic logic [1:0] region(input int who);
    case (who)
      1: return 2'b01;
      2: return 2'b10;
      3: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic rand_client(input int who, input int n);
    logic        wr;
    logic [20:0] a;
    logic [7:0]  d;
    int          lat, g;
    for (int i = 0; i < n; i++) begin
      wr = (who == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      a  = {region(who), 15'd0, 4'($urandom_range(0, 15))};
      d  = 8'($urandom);
      issue(who, wr, a, d, lat);
      g = $urandom_range(0, 3);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- reference model of the shared bus ----------------
  // m_left: cycles left in the current transfer (AC strobe cycles + 1 ack cycle)
  bit          mon_en = 0;
  int          m_left = 0;
  int          m_owner = 0;
  int          m_starve = 0;
  logic        m_wr = 0;
  logic [20:0] m_addr = 0;
  logic [7:0]  m_data = 0;
  int          own_log[$];
  logic [2:0]  last_owner = 3'd0;

  function automatic int model_pick(input bit l, input bit v, input bit d,
                                    input bit c, input bit starved);
    int order[$];
    bit r;
    if (starved) order = '{3, 1, 2, 4};
    else         order = '{3, 2, 4, 1};
    foreach (order[k]) begin
      case (order[k])
        1: r = c;
        2: r = v;
        3: r = l;
        default: r = d;
      endcase
      if (r) return order[k];
    end
    return 0;
  endfunction

  task automatic pop_check(input int who, input logic [7:0] qv);
    item_t it;
    int    sz;
    case (who)
      1: sz = sb_cpu.size();
      2: sz = sb_vid.size();
      3: sz = sb_ldr.size();
      default: sz = sb_dma.size();
    endcase
    if (sz == 0) begin
      n_vec++; n_err++;
      $display("FAIL spurious_ack: requester %0d acked with empty scoreboard", who);
      return;
    end
    case (who)
      1: it = sb_cpu.pop_front();
      2: it = sb_vid.pop_front();
      3: it = sb_ldr.pop_front();
      default: it = sb_dma.pop_front();
    endcase
    $display("txn who=%0d wr=%0d a=%05h d=%02h q=%02h exp_q=%02h", who, it.wr, it.a, it.d, qv, it.q);
    check($sformatf("ack_addr%0d", who), 32'(sram_a), 32'(it.a));
    if (it.wr)
      check($sformatf("mem_write%0d", who), 32'(mem_get(it.a)), 32'(it.d));
    else if (who != 3)
      check($sformatf("read_q%0d", who), 32'(qv), 32'(it.q));
  endtask

  always @(negedge clk) begin
    bit l, v, d, c;
    int nxt;
    if (mon_en && !reset) begin
      // timing and pad behaviour of the transfer the model says is running
      check("owner", 32'(owner), 32'(m_owner));
      check("strobes", {29'd0, sram_we_n, sram_oe_n, sram_doe},
            {29'd0, !(m_left > 1 && m_wr), !(m_left > 1 && !m_wr), (m_left >= 1) && m_wr});
      check("acks", {28'd0, ldr_ack, vid_ack, cpu_ack, dma_ack},
            {28'd0, m_left == 1 && m_owner == 3, m_left == 1 && m_owner == 2,
             m_left == 1 && m_owner == 1, m_left == 1 && m_owner == 4});
      if (m_left >= 1) check("bus_addr", 32'(sram_a), 32'(m_addr));
      if (m_left >= 1 && m_wr) check("bus_wdata", 32'(sram_dout), 32'(m_data));
      if (owner != last_owner) own_log.push_back(int'(owner));
      last_owner = owner;

      if (cpu_ack) pop_check(1, cpu_q);
      if (vid_ack) pop_check(2, vid_q);
      if (ldr_ack) pop_check(3, 8'h00);
      if (dma_ack) pop_check(4, dma_q);

      // arbitration happens when the bus is idle or in the ack cycle
      l = ldr_req; v = vid_req; d = dma_req; c = cpu_req;
      if (m_left == 1) begin
        if (m_owner == 3) l = 0;
        if (m_owner == 2) v = 0;
        if (m_owner == 4) d = 0;
        if (m_owner == 1) c = 0;
      end
      if (m_left <= 1) begin
        nxt = model_pick(l, v, d, c, m_starve == SMAX);
        if (!c) m_starve = 0;
        if (nxt != 0) begin
          if (nxt == 1) m_starve = 0;
          else if (c && m_starve < SMAX) m_starve++;
          m_owner = nxt;
          m_left  = AC + 1;
          case (nxt)
            1: begin m_wr = cpu_wr; m_addr = cpu_a; m_data = cpu_d; end
            2: begin m_wr = 1'b0;   m_addr = vid_a; m_data = m_data; end
            3: begin m_wr = ldr_wr; m_addr = ldr_a; m_data = ldr_d; end
            default: begin m_wr = dma_wr; m_addr = dma_a; m_data = dma_d; end
          endcase
        end else begin
          m_owner = 0;
          m_left  = 0;
        end
      end else begin
        if (!c) m_starve = 0;
        m_left--;
      end
    end
  end

  // hard stop if something hangs despite the per-transfer bounds
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int lat, cnt, k;
    int exp_seq[$];

    // reset state
    repeat (2) @(negedge clk);
    check("reset_state",
          {sram_a[15:0], sram_dout, owner, sram_we_n, sram_oe_n, sram_doe, ldr_ack, vid_ack},
          {16'h0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_q", {cpu_ack, sram_a[20:16], vid_q, cpu_q}, 22'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // reset while a write is strobing
    cpu_wr = 1'b1; cpu_a = 21'h12345; cpu_d = 8'hA7; cpu_req = 1'b1;
    cnt = 0;
    while (sram_we_n !== 1'b0 && cnt < 20) begin @(negedge clk); cnt++; end
    check("write_started", 32'(sram_we_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {29'd0, sram_we_n, sram_doe, sram_oe_n}, {29'd0, 1'b1, 1'b0, 1'b1});
    check("async_reset_owner", 32'(owner), 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ldr_ack || vid_ack || cpu_ack || dma_ack) cnt++;
    end
    check("no_ack_after_reset", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    m_left = 0; m_owner = 0; m_starve = 0; last_owner = 3'd0;
    mon_en = 1;

    // CPU read with known memory content, latency grant+3
    mem[int'(21'h0A5A5)] = 8'h3C;
    ref_mem[int'(21'h0A5A5)] = 8'h3C;
    issue(1, 1'b0, 21'h0A5A5, 8'h00, lat);
    check("cpu_read_latency", 32'(lat), 32'(AC + 2));
    check("cpu_q_0A5A5", 32'(cpu_q), 32'h3C);

    // CPU write then read back
    issue(1, 1'b1, 21'h1F000, 8'h81, lat);
    check("cpu_write_latency", 32'(lat), 32'(AC + 2));
    issue(1, 1'b0, 21'h1F000, 8'h00, lat);
    check("cpu_readback", 32'(cpu_q), 32'h81);

    // three requesters at once: ldr, vid, cpu
    repeat (2) @(posedge clk); #1;
    own_log.delete();
    fork
      issue(3, 1'b1, 21'h1C001, 8'h55, lat);
      issue(2, 1'b0, 21'h10002, 8'h00, lat);
      issue(1, 1'b0, 21'h08003, 8'h00, lat);
    join
    repeat (3) @(posedge clk); #1;
    exp_seq = '{3, 2, 1, 0};
    check("owner_seq_len", 32'(own_log.size()), 32'(exp_seq.size()));
    k = (own_log.size() < exp_seq.size()) ? own_log.size() : exp_seq.size();
    for (int i = 0; i < k; i++) check($sformatf("owner_seq%0d", i), 32'(own_log[i]), 32'(exp_seq[i]));

`ifdef SRAM_ARB_DMA_EN
    // DMA beats CPU when both request together
    own_log.delete();
    fork
      issue(4, 1'b0, 21'h00020, 8'h00, lat);
      issue(1, 1'b0, 21'h08004, 8'h00, lat);
    join
    repeat (3) @(posedge clk); #1;
    exp_seq = '{4, 1, 0};
    check("dma_seq_len", 32'(own_log.size()), 32'(exp_seq.size()));
    k = (own_log.size() < exp_seq.size()) ? own_log.size() : exp_seq.size();
    for (int i = 0; i < k; i++) check($sformatf("dma_seq%0d", i), 32'(own_log[i]), 32'(exp_seq[i]));
`endif

    // loader and video hammer the bus while the CPU waits
    fork
      for (int i = 0; i < 6; i++) begin
        int l1;
        issue(3, 1'b1, {2'b11, 15'd0, 4'(i)}, 8'(i * 17), l1);
      end
      for (int i = 0; i < 6; i++) begin
        int l2;
        issue(2, 1'b0, {2'b10, 15'd0, 4'(i)}, 8'h00, l2);
      end
      begin
        int l3;
        issue(1, 1'b0, {2'b01, 15'd0, 4'd7}, 8'h00, l3);
      end
    join

    // randomized traffic from every requester
    fork
      rand_client(1, 40);
      rand_client(2, 40);
      rand_client(3, 40);
`ifdef SRAM_ARB_DMA_EN
      rand_client(4, 40);
`endif
    join

    repeat (6) @(posedge clk); #1;
    check("scoreboards_drained", 32'(sb_cpu.size() + sb_vid.size() + sb_ldr.size() + sb_dma.size()), 32'd0);
    check("bus_idle_at_end", {29'd0, owner}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
